// File: rtl/controlador_transacao.sv
// Vending-machine transaction sequencer: selection, coin accumulation, timed dispense, change/refund.
// Define TROCO_EN to return overpayment after a dispense; undefined, the excess is retained.
module controlador_transacao #(
  parameter int LARGURA_CREDITO = 8,
  parameter int CICLOS_ENTREGA  = 16,
  parameter int CICLOS_TIMEOUT  = 1000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       sel_valida,
  input  logic [3:0]                 sel_produto,
  input  logic                       estoque_ok,
  input  logic [LARGURA_CREDITO-1:0] preco,
  input  logic                       moeda_valida,
  input  logic [LARGURA_CREDITO-1:0] moeda_valor,
  input  logic                       cancelar,
  output logic [1:0]                 estado,
  output logic [3:0]                 produto_saida,
  output logic [LARGURA_CREDITO-1:0] credito,
  output logic                       entregar,
  output logic                       troco_valido,
  output logic [LARGURA_CREDITO-1:0] troco_valor,
  output logic                       erro_estoque
);

  localparam int W  = LARGURA_CREDITO;
  localparam int TW = (CICLOS_TIMEOUT > 2) ? $clog2(CICLOS_TIMEOUT) : 1;
  localparam int EW = $clog2(CICLOS_ENTREGA + 1);

  typedef enum logic [1:0] {
    OCIOSO    = 2'd0,
    PAGAMENTO = 2'd1,
    ENTREGA   = 2'd2,
    DEVOLUCAO = 2'd3
  } estado_t;

  estado_t         estado_q;
  logic [3:0]      produto_q;
  logic [W-1:0]    preco_q;
  logic [W-1:0]    credito_q;
  logic [W-1:0]    credito_d;
  logic [W-1:0]    troco_valor_q;
  logic [W-1:0]    troco_entrega;
  logic [W:0]      soma;
  logic [TW-1:0]   timer_q;
  logic [EW-1:0]   entrega_q;
  logic            entregar_q;
  logic            troco_valido_q;
  logic            erro_q;

  // Credit including this cycle's coin, saturating at the all-ones value.
  always_comb begin
    soma      = {1'b0, credito_q} + {1'b0, moeda_valor};
    credito_d = credito_q;
    if (moeda_valida) begin
      credito_d = soma[W] ? {W{1'b1}} : soma[W-1:0];
    end
  end

`ifdef TROCO_EN
  assign troco_entrega = credito_d - preco_q;
`else
  assign troco_entrega = '0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      estado_q       <= OCIOSO;
      produto_q      <= '0;
      preco_q        <= '0;
      credito_q      <= '0;
      timer_q        <= '0;
      entrega_q      <= '0;
      entregar_q     <= 1'b0;
      troco_valido_q <= 1'b0;
      troco_valor_q  <= '0;
      erro_q         <= 1'b0;
    end else begin
      // NOTE: strobes default low every cycle so any set below lasts exactly one clock.
      erro_q         <= 1'b0;
      troco_valido_q <= 1'b0;
      troco_valor_q  <= '0;
      case (estado_q)
        OCIOSO: begin
          if (sel_valida) begin
            if (estoque_ok) begin
              produto_q <= sel_produto;
              preco_q   <= preco;
              credito_q <= '0;
              timer_q   <= '0;
              estado_q  <= PAGAMENTO;
            end else begin
              erro_q <= 1'b1;
            end
          end
        end
        PAGAMENTO: begin
          credito_q <= credito_d;
          timer_q   <= moeda_valida ? '0 : timer_q + TW'(1);
          if (credito_q >= preco_q) begin
            entregar_q <= 1'b1;
            entrega_q  <= '0;
            estado_q   <= ENTREGA;
          end else if (cancelar || timer_q == TW'(CICLOS_TIMEOUT - 1)) begin
            troco_valido_q <= (credito_d != '0);
            troco_valor_q  <= credito_d;
            estado_q       <= DEVOLUCAO;
          end
        end
        ENTREGA: begin
          credito_q <= credito_d;
          if (entrega_q == EW'(CICLOS_ENTREGA - 1)) begin
            entregar_q     <= 1'b0;
            troco_valido_q <= (troco_entrega != '0);
            troco_valor_q  <= troco_entrega;
            estado_q       <= DEVOLUCAO;
          end else begin
            entrega_q <= entrega_q + EW'(1);
          end
        end
        DEVOLUCAO: begin
          credito_q <= '0;
          estado_q  <= OCIOSO;
        end
        default: estado_q <= OCIOSO;
      endcase
    end
  end

  assign estado        = estado_q;
  assign produto_saida = produto_q;
  assign credito       = credito_q;
  assign entregar      = entregar_q;
  assign troco_valido  = troco_valido_q;
  assign troco_valor   = troco_valor_q;
  assign erro_estoque  = erro_q;

endmodule

// File: tb/tb_controlador_transacao.sv
// Self-checking bench for controlador_transacao: directed scenarios plus random transactions
// whose outcome (dispense/cancel/timeout, credit, change) is computed arithmetically.
module tb_controlador_transacao;

  localparam int LC   = 8;
  localparam int CE   = 16;
  localparam int CT   = 40;
  localparam int MAXC = (1 << LC) - 1;

`ifdef TROCO_EN
  localparam bit TROCO = 1'b1;
`else
  localparam bit TROCO = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          sel_valida;
  logic [3:0]    sel_produto;
  logic          estoque_ok;
  logic [LC-1:0] preco;
  logic          moeda_valida;
  logic [LC-1:0] moeda_valor;
  logic          cancelar;
  logic [1:0]    estado;
  logic [3:0]    produto_saida;
  logic [LC-1:0] credito;
  logic          entregar;
  logic          troco_valido;
  logic [LC-1:0] troco_valor;
  logic          erro_estoque;

  int checks = 0;
  int errors = 0;
  int moedas[$];

  always #5 clk = ~clk;

  controlador_transacao #(
    .LARGURA_CREDITO(LC),
    .CICLOS_ENTREGA (CE),
    .CICLOS_TIMEOUT (CT)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .sel_valida   (sel_valida),
    .sel_produto  (sel_produto),
    .estoque_ok   (estoque_ok),
    .preco        (preco),
    .moeda_valida (moeda_valida),
    .moeda_valor  (moeda_valor),
    .cancelar     (cancelar),
    .estado       (estado),
    .produto_saida(produto_saida),
    .credito      (credito),
    .entregar     (entregar),
    .troco_valido (troco_valido),
    .troco_valor  (troco_valor),
    .erro_estoque (erro_estoque)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic solta();
    sel_valida   = 1'b0;
    moeda_valida = 1'b0;
    moeda_valor  = '0;
    cancelar     = 1'b0;
  endtask

  function automatic int sat(input int v);
    return (v > MAXC) ? MAXC : v;
  endfunction

  // One complete transaction driven from OCIOSO back to OCIOSO using the coins in `moedas`.
  task automatic transacao(input logic [3:0] prod, input int price, input int cancel_idx,
                           input int extra_trans, input int extra_entr);
    int c, n, k, outcome, change, ociosos;
    sel_valida  = 1'b1;
    estoque_ok  = 1'b1;
    sel_produto = prod;
    preco       = LC'(price);
    tick();
    solta();
    check("sel_estado", estado, 1);
    check("sel_produto", produto_saida, prod);
    check("sel_credito", credito, 0);
    c = 0;
    outcome = 0;
    ociosos = 0;
    foreach (moedas[i]) begin
      if (c >= price) break;
      moeda_valida = (moedas[i] != 0);
      moeda_valor  = LC'(moedas[i]);
      cancelar     = (i == cancel_idx);
      c = sat(c + moedas[i]);
      ociosos = (moedas[i] != 0) ? 0 : ociosos + 1;
      tick();
      solta();
      check("moeda_credito", credito, c);
      if (i == cancel_idx) begin
        outcome = 2;
        break;
      end
      check("moeda_estado", estado, 1);
    end
    if (outcome != 2) outcome = (c >= price) ? 1 : 0;
    if (outcome == 1) begin
      moeda_valida = (extra_trans != 0);
      moeda_valor  = LC'(extra_trans);
      c = sat(c + extra_trans);
      tick();
      solta();
      check("entrega_estado", estado, 2);
      check("entrega_inicio", entregar, 1);
      check("entrega_credito", credito, c);
      n = 1;
      while (n < CE + 4) begin
        if (n == 3) begin
          moeda_valida = (extra_entr != 0);
          moeda_valor  = LC'(extra_entr);
          c = sat(c + extra_entr);
        end
        tick();
        solta();
        if (entregar !== 1'b1) break;
        n++;
      end
      check("entrega_ciclos", n, CE);
      change = TROCO ? c - price : 0;
    end else if (outcome == 0) begin
      k = 0;
      while (estado === 2'd1 && k < CT + 4) begin
        tick();
        k++;
      end
      check("timeout_ciclos", k, CT - ociosos);
      change = c;
    end else begin
      change = c;
    end
    check("dev_estado", estado, 3);
    check("dev_entregar", entregar, 0);
    check("dev_valido", troco_valido, (change != 0));
    check("dev_valor", troco_valor, change);
    tick();
    check("fim_estado", estado, 0);
    check("fim_credito", credito, 0);
    check("fim_troco", troco_valido, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int price, nm, cidx;
    reset       = 1'b1;
    estoque_ok  = 1'b0;
    sel_produto = '0;
    preco       = '0;
    solta();
    tick();
    tick();
    reset = 1'b0;
    check("rst_estado", estado, 0);
    check("rst_credito", credito, 0);
    check("rst_produto", produto_saida, 0);
    check("rst_entregar", entregar, 0);
    check("rst_troco_valido", troco_valido, 0);
    check("rst_troco_valor", troco_valor, 0);
    check("rst_erro", erro_estoque, 0);

    // Out of stock: one-cycle error pulse, machine stays idle.
    sel_valida  = 1'b1;
    estoque_ok  = 1'b0;
    sel_produto = 4'd3;
    preco       = 8'd9;
    tick();
    solta();
    check("sem_estoque_erro", erro_estoque, 1);
    check("sem_estoque_estado", estado, 0);
    tick();
    check("sem_estoque_pulso", erro_estoque, 0);
    check("sem_estoque_estado2", estado, 0);

    // Coins while idle are ignored.
    moeda_valida = 1'b1;
    moeda_valor  = 8'd9;
    tick();
    solta();
    check("ocioso_moeda", credito, 0);

    moedas = '{5, 5};
    transacao(4'd5, 10, -1, 0, 0);
    moedas = '{5, 5};
    transacao(4'd2, 7, -1, 0, 0);
    moedas = '{5, 2};
    transacao(4'd7, 20, 1, 0, 0);
    moedas = {};
    transacao(4'd1, 20, -1, 0, 0);
    moedas = '{200, 100};
    transacao(4'd9, 250, -1, 0, 0);
    moedas = '{200, 100};
    transacao(4'd4, 255, 1, 0, 0);
    moedas = {};
    transacao(4'd0, 0, -1, 4, 6);

    // Reset during the fourth dispense cycle.
    sel_valida  = 1'b1;
    estoque_ok  = 1'b1;
    sel_produto = 4'd6;
    preco       = 8'd3;
    tick();
    solta();
    moeda_valida = 1'b1;
    moeda_valor  = 8'd4;
    tick();
    solta();
    tick();
    check("rst_meio_entrando", entregar, 1);
    tick();
    tick();
    tick();
    check("rst_meio_ciclo4", entregar, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_meio_entregar", entregar, 0);
    check("rst_meio_estado", estado, 0);
    check("rst_meio_credito", credito, 0);
    check("rst_meio_produto", produto_saida, 0);
    tick();
    check("rst_meio_sem_troco", troco_valido, 0);
    check("rst_meio_ocioso", estado, 0);

    for (int t = 0; t < 25; t++) begin
      price = int'($urandom_range(0, 60));
      nm    = int'($urandom_range(0, 6));
      moedas = {};
      for (int j = 0; j < nm; j++) begin
        moedas.push_back(($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 30)));
      end
      cidx = (nm > 0 && $urandom_range(0, 2) == 0) ? int'($urandom_range(0, nm - 1)) : -1;
      transacao(4'($urandom_range(0, 15)), price, cidx,
                int'($urandom_range(0, 20)), int'($urandom_range(0, 20)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
